// File: rtl/ram_bytelane.sv
// ram_bytelane: byte-addressed little-endian RAM with a req/ready/valid handshake and bounds checking.
// Define RAM_SIGNED_LOAD_EN to add I_signed for sign-extended loads.
//
// state | meaning
// IDLE  | accepting a request (O_ready=1)
// WAIT  | read latency countdown, READ_LAT-1 cycles
// RESP  | one-cycle O_valid response
module ram_bytelane #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 4096,
    parameter int READ_LAT    = 1
) (
    input  logic              I_clk,
    input  logic              I_reset,
    input  logic              I_req,
    output logic              O_ready,
    input  logic              I_write,
    input  logic [1:0]        I_size,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic [DATA_W-1:0] I_data_in,
`ifdef RAM_SIGNED_LOAD_EN
    input  logic              I_signed,
`endif
    output logic [DATA_W-1:0] O_data_out,
    output logic              O_valid,
    output logic              O_err
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [7:0]        mem_q [DEPTH_BYTES];
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] data_out_q;

    logic              accept;
    logic [2:0]        nbytes;
    logic              size_bad;
    logic [ADDR_W:0]   last_addr;
    logic              req_err;
    logic [ADDR_W:0]   lane_addr [LANES];
    logic [LANES-1:0]  lane_en;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] resp_data_d;
`ifdef RAM_SIGNED_LOAD_EN
    logic              sign_bit;
`endif

    assign O_ready    = (state_q == IDLE) && !I_reset;
    assign accept     = I_req && O_ready;
    assign O_valid    = valid_q;
    assign O_err      = err_q;
    assign O_data_out = data_out_q;

    // Request decode: width, bounds (one extra bit so the end address never wraps), lane data.
    always_comb begin
        nbytes   = 3'd0;
        size_bad = 1'b0;
        case (I_size)
            2'd1:    nbytes = 3'd1;
            2'd2:    nbytes = 3'd2;
            2'd3: begin
                nbytes   = 3'd4;
                size_bad = (DATA_W < 32);
            end
            default: size_bad = 1'b1;
        endcase

        last_addr = {1'b0, I_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
        req_err   = size_bad || (last_addr >= (ADDR_W+1)'(DEPTH_BYTES));

        rdata_d = '0;
        lane_en = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = {1'b0, I_addr} + (ADDR_W+1)'(i);
            lane_en[i]   = (3'(i) < nbytes) && !req_err
                           && (lane_addr[i] < (ADDR_W+1)'(DEPTH_BYTES));
            if (lane_en[i]) begin
                rdata_d[8*i +: 8] = mem_q[lane_addr[i][IDX_W-1:0]];
            end
        end

`ifdef RAM_SIGNED_LOAD_EN
        case (nbytes)
            3'd1:    sign_bit = rdata_d[7];
            3'd2:    sign_bit = rdata_d[15];
            default: sign_bit = rdata_d[DATA_W-1];
        endcase
        if (I_signed) begin
            for (int i = 0; i < LANES; i++) begin
                if (3'(i) >= nbytes) begin
                    rdata_d[8*i +: 8] = {8{sign_bit}};
                end
            end
        end
`endif

        resp_data_d = (I_write || req_err) ? '0 : rdata_d;
    end

    // Writes commit on the accept edge, so an accepted write survives a later reset.
    always_ff @(posedge I_clk) begin
        if (accept && I_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) begin
                    mem_q[lane_addr[i][IDX_W-1:0]] <= I_data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        resp_err_q  <= req_err;
                        resp_data_q <= resp_data_d;
                        if (!I_write && (READ_LAT > 1)) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(READ_LAT - 2);
                        end else begin
                            state_q    <= RESP;
                            valid_q    <= 1'b1;
                            err_q      <= req_err;
                            data_out_q <= resp_data_d;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q    <= RESP;
                        valid_q    <= 1'b1;
                        err_q      <= resp_err_q;
                        data_out_q <= resp_data_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bytelane.sv
// Bench for ram_bytelane: two instances (READ_LAT 1 and 3), directed vector table,
// hand-written reset/ignored-request sequences and random traffic against a byte-array model.
module tb_ram_bytelane;

`ifdef RAM_SIGNED_LOAD_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam int DEPTH = 4096;
    localparam int LAT [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst_i   [2];
    logic        req_i   [2];
    logic        write_i [2];
    logic [1:0]  size_i  [2];
    logic [15:0] addr_i  [2];
    logic [31:0] data_i  [2];
    logic        sgn_i   [2];
    logic        ready_o [2];
    logic [31:0] data_o  [2];
    logic        valid_o [2];
    logic        err_o   [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [2][DEPTH];

    always #5 clk = ~clk;

    ram_bytelane #(.ADDR_W(16), .DATA_W(32), .DEPTH_BYTES(DEPTH), .READ_LAT(1)) dut1 (
        .I_clk(clk), .I_reset(rst_i[0]), .I_req(req_i[0]), .O_ready(ready_o[0]),
        .I_write(write_i[0]), .I_size(size_i[0]), .I_addr(addr_i[0]), .I_data_in(data_i[0]),
`ifdef RAM_SIGNED_LOAD_EN
        .I_signed(sgn_i[0]),
`endif
        .O_data_out(data_o[0]), .O_valid(valid_o[0]), .O_err(err_o[0])
    );

    ram_bytelane #(.ADDR_W(16), .DATA_W(32), .DEPTH_BYTES(DEPTH), .READ_LAT(3)) dut3 (
        .I_clk(clk), .I_reset(rst_i[1]), .I_req(req_i[1]), .O_ready(ready_o[1]),
        .I_write(write_i[1]), .I_size(size_i[1]), .I_addr(addr_i[1]), .I_data_in(data_i[1]),
`ifdef RAM_SIGNED_LOAD_EN
        .I_signed(sgn_i[1]),
`endif
        .O_data_out(data_o[1]), .O_valid(valid_o[1]), .O_err(err_o[1])
    );

    typedef struct {
        int          w;
        bit          wr;
        logic [1:0]  size;
        logic [15:0] addr;
        logic [31:0] data;
        bit          sgn;
        bit          e_err;
        logic [31:0] e_data;
        int          e_lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: N-byte little-endian access on a plain byte array.
    function automatic void model_access(input int w, input bit wr, input logic [1:0] size,
                                         input logic [15:0] addr, input logic [31:0] data,
                                         input bit sgn, output bit err,
                                         output logic [31:0] rd, output int lat);
        int n;
        longint v;
        n   = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : (size == 2'd3) ? 4 : 0;
        err = (n == 0) || (int'(addr) + n - 1 >= DEPTH);
        lat = wr ? 1 : LAT[w];
        rd  = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int k = 0; k < n; k++) mem_m[w][int'(addr) + k] = data[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v + (longint'(mem_m[w][int'(addr) + k]) << (8*k));
                if (SIGNED_EN && sgn && v[8*n-1]) v = v - (longint'(1) << (8*n));
                rd = v[31:0];
            end
        end
    endfunction

    task automatic do_access(input int w, input bit wr, input logic [1:0] size,
                             input logic [15:0] addr, input logic [31:0] data, input bit sgn,
                             output bit got_err, output logic [31:0] got_data, output int got_lat);
        int guard;
        got_err  = 1'b0;
        got_data = 32'h0;
        got_lat  = -1;
        guard    = 0;
        while (ready_o[w] !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) begin
            check_eq("ready_timeout", 32'(ready_o[w]), 32'h1);
            return;
        end
        req_i[w] = 1'b1; write_i[w] = wr; size_i[w] = size;
        addr_i[w] = addr; data_i[w] = data; sgn_i[w] = sgn;
        @(posedge clk); #1;
        // Scramble fields after accept; they must not matter.
        req_i[w] = 1'b0; write_i[w] = 1'($urandom); size_i[w] = 2'($urandom);
        addr_i[w] = 16'($urandom); data_i[w] = $urandom; sgn_i[w] = 1'($urandom);
        for (int c = 1; c <= 10; c++) begin
            if (valid_o[w] === 1'b1) begin
                got_lat  = c;
                got_err  = err_o[w];
                got_data = data_o[w];
                break;
            end
            check_eq("ready_low_wait", 32'(ready_o[w]), 32'h0);
            @(posedge clk); #1;
        end
        if (got_lat < 0) begin
            check_eq("valid_timeout", 32'(valid_o[w]), 32'h1);
            return;
        end
        check_eq("ready_low_resp", 32'(ready_o[w]), 32'h0);
        @(posedge clk); #1;
        check_eq("valid_one_pulse", 32'(valid_o[w]), 32'h0);
        check_eq("ready_after_resp", 32'(ready_o[w]), 32'h1);
    endtask

    task automatic run_model_op(input int w, input bit wr, input logic [1:0] size,
                                input logic [15:0] addr, input logic [31:0] data, input bit sgn);
        bit e_err, g_err;
        logic [31:0] e_data, g_data;
        int e_lat, g_lat;
        model_access(w, wr, size, addr, data, sgn, e_err, e_data, e_lat);
        do_access(w, wr, size, addr, data, sgn, g_err, g_data, g_lat);
        if (g_lat >= 0) begin
            check_eq("model_err", 32'(g_err), 32'(e_err));
            check_eq("model_data", g_data, e_data);
            check_eq("model_lat", g_lat, e_lat);
        end
    endtask

    function automatic vec_t mk(input int w, input bit wr, input logic [1:0] size,
                                input logic [15:0] addr, input logic [31:0] data, input bit sgn,
                                input bit e_err, input logic [31:0] e_data, input int e_lat);
        vec_t v;
        v.w = w; v.wr = wr; v.size = size; v.addr = addr; v.data = data; v.sgn = sgn;
        v.e_err = e_err; v.e_data = e_data; v.e_lat = e_lat;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g_err, m_err;
        logic [31:0] g_data, m_data;
        int g_lat, m_lat, r;
        logic [15:0] a;

        for (int w = 0; w < 2; w++) begin
            rst_i[w] = 1'b1; req_i[w] = 1'b0; write_i[w] = 1'b0; size_i[w] = 2'd0;
            addr_i[w] = '0; data_i[w] = '0; sgn_i[w] = 1'b0;
        end

        // Reset for two cycles.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            for (int w = 0; w < 2; w++) begin
                check_eq("rst_ready", 32'(ready_o[w]), 32'h0);
                check_eq("rst_valid", 32'(valid_o[w]), 32'h0);
                check_eq("rst_data", data_o[w], 32'h0);
            end
        end
        rst_i[0] = 1'b0; rst_i[1] = 1'b0;
        @(posedge clk); #1;
        for (int w = 0; w < 2; w++) begin
            check_eq("post_rst_ready", 32'(ready_o[w]), 32'h1);
            check_eq("post_rst_valid", 32'(valid_o[w]), 32'h0);
        end

        // Fill low and top regions so every random access hits known bytes.
        for (int w = 0; w < 2; w++) begin
            for (int ad = 0; ad < 'h200; ad += 4) run_model_op(w, 1'b1, 2'd3, 16'(ad), $urandom, 1'b0);
            for (int ad = 'hF00; ad < DEPTH; ad += 4) run_model_op(w, 1'b1, 2'd3, 16'(ad), $urandom, 1'b0);
        end

        // w  wr size addr      data          sgn  err data          lat
        tbl.push_back(mk(0, 1, 3, 16'h0101, 32'hDEADBEEF, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 1, 16'h0102, 32'h0,        0, 0, 32'h000000BE, 1));
        tbl.push_back(mk(0, 0, 1, 16'h0103, 32'h0,        0, 0, 32'h000000AD, 1));
        tbl.push_back(mk(0, 0, 3, 16'h0101, 32'h0,        0, 0, 32'hDEADBEEF, 1));
        tbl.push_back(mk(0, 0, 2, 16'h0103, 32'h0,        0, 0, 32'h0000DEAD, 1));
        tbl.push_back(mk(0, 1, 1, 16'h0FFE, 32'h00000077, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 1, 3, 16'h0FFE, 32'h11223344, 0, 1, 32'h0, 1));
        tbl.push_back(mk(0, 0, 1, 16'h0FFE, 32'h0,        0, 0, 32'h00000077, 1));
        tbl.push_back(mk(0, 1, 1, 16'h0FFF, 32'hABCDEF5A, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 1, 16'h0FFF, 32'h0,        0, 0, 32'h0000005A, 1));
        tbl.push_back(mk(0, 0, 2, 16'h0FFE, 32'h0,        0, 0, 32'h00005A77, 1));
        tbl.push_back(mk(0, 0, 2, 16'h0FFF, 32'h0,        0, 1, 32'h0, 1));
        tbl.push_back(mk(0, 0, 3, 16'hFFFF, 32'h0,        0, 1, 32'h0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0010, 32'h0,        0, 1, 32'h0, 1));
        tbl.push_back(mk(0, 1, 0, 16'h0010, 32'h0,        0, 1, 32'h0, 1));
        tbl.push_back(mk(0, 1, 1, 16'h0010, 32'h00000080, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 1, 16'h0010, 32'h0,        1, 0, SIGNED_EN ? 32'hFFFFFF80 : 32'h00000080, 1));
        tbl.push_back(mk(0, 0, 1, 16'h0010, 32'h0,        0, 0, 32'h00000080, 1));
        tbl.push_back(mk(0, 1, 2, 16'h0030, 32'h00008001, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 2, 16'h0030, 32'h0,        1, 0, SIGNED_EN ? 32'hFFFF8001 : 32'h00008001, 1));
        tbl.push_back(mk(0, 1, 3, 16'h0040, 32'h7F00FF80, 0, 0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 3, 16'h0040, 32'h0,        1, 0, 32'h7F00FF80, 1));
        tbl.push_back(mk(0, 0, 1, 16'h0041, 32'h0,        1, 0, SIGNED_EN ? 32'hFFFFFFFF : 32'h000000FF, 1));
        tbl.push_back(mk(0, 1, 1, 16'h0010, 32'h00000012, 1, 0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 1, 16'h0010, 32'h0,        0, 0, 32'h00000012, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0010, 32'h0,        1, 1, 32'h0, 1));
        tbl.push_back(mk(1, 1, 3, 16'h0101, 32'hDEADBEEF, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, 0, 2, 16'h0101, 32'h0,        0, 0, 32'h0000BEEF, 3));
        tbl.push_back(mk(1, 0, 1, 16'h0104, 32'h0,        0, 0, 32'h000000DE, 3));
        tbl.push_back(mk(1, 0, 1, 16'h1000, 32'h0,        0, 1, 32'h0, 3));
        tbl.push_back(mk(1, 1, 2, 16'h0FFF, 32'h0000ABCD, 0, 1, 32'h0, 1));
        tbl.push_back(mk(1, 0, 0, 16'h0020, 32'h0,        1, 1, 32'h0, 3));

        foreach (tbl[i]) begin
            model_access(tbl[i].w, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].data, tbl[i].sgn,
                         m_err, m_data, m_lat);
            do_access(tbl[i].w, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].data, tbl[i].sgn,
                      g_err, g_data, g_lat);
            if (g_lat >= 0) begin
                check_eq($sformatf("vec%0d_err", i), 32'(g_err), 32'(tbl[i].e_err));
                check_eq($sformatf("vec%0d_data", i), g_data, tbl[i].e_data);
                check_eq($sformatf("vec%0d_lat", i), g_lat, tbl[i].e_lat);
            end
        end

        // Request pulsed during WAIT is dropped, not queued.
        model_access(1, 1'b0, 2'd3, 16'h0100, 32'h0, 1'b0, m_err, m_data, m_lat);
        req_i[1] = 1'b1; write_i[1] = 1'b0; size_i[1] = 2'd3; addr_i[1] = 16'h0100; sgn_i[1] = 1'b0;
        @(posedge clk); #1;
        req_i[1] = 1'b1; write_i[1] = 1'b1; size_i[1] = 2'd3; addr_i[1] = 16'h0150; data_i[1] = 32'hFFFFFFFF;
        check_eq("wait_ready", 32'(ready_o[1]), 32'h0);
        @(posedge clk); #1;
        req_i[1] = 1'b0;
        check_eq("wait_valid_early", 32'(valid_o[1]), 32'h0);
        @(posedge clk); #1;
        check_eq("ign_valid", 32'(valid_o[1]), 32'h1);
        check_eq("ign_data", data_o[1], m_data);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_eq("ign_no_extra_valid", 32'(valid_o[1]), 32'h0);
        end
        run_model_op(1, 1'b0, 2'd3, 16'h0150, 32'h0, 1'b0);

        // Reset during WAIT drops the pending read.
        req_i[1] = 1'b1; write_i[1] = 1'b0; size_i[1] = 2'd2; addr_i[1] = 16'h0100;
        @(posedge clk); #1;
        req_i[1] = 1'b0;
        rst_i[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_eq("midrst_ready", 32'(ready_o[1]), 32'h0);
            check_eq("midrst_valid", 32'(valid_o[1]), 32'h0);
        end
        rst_i[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_eq("after_rst_valid", 32'(valid_o[1]), 32'h0);
            check_eq("after_rst_ready", 32'(ready_o[1]), 32'h1);
            check_eq("after_rst_data", data_o[1], 32'h0);
        end

        // Write accepted just before reset stays committed.
        model_access(0, 1'b1, 2'd2, 16'h0180, 32'h0000C0DE, 1'b0, m_err, m_data, m_lat);
        req_i[0] = 1'b1; write_i[0] = 1'b1; size_i[0] = 2'd2; addr_i[0] = 16'h0180; data_i[0] = 32'h0000C0DE;
        @(posedge clk); #1;
        req_i[0] = 1'b0;
        rst_i[0] = 1'b1;
        @(posedge clk); #1;
        rst_i[0] = 1'b0;
        run_model_op(0, 1'b0, 2'd2, 16'h0180, 32'h0, 1'b0);

        // Random traffic against the model.
        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 200; n++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      a = 16'($urandom_range(0, 'h1F0));
                else if (r < 9) a = 16'($urandom_range('hFF0, 'hFFF));
                else            a = 16'($urandom_range('h1000, 'hFFFF));
                run_model_op(w, 1'($urandom), 2'($urandom), a, $urandom, 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
